rggen_bus_arbiter: RTL and testbench

- Shares one rggen register-bus target (the adapter/register-block slave side) between HOSTS independent bus masters.
- Arbitrates among requesting hosts, forwards the winner's command to the slave, and locks the grant until the slave returns ready.
- Routes ready/status/read_data back to the granted host only.
- Sits between host bridges (CPU, debug, DMA) and a single rggen register block.

---
 rtl/rggen_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_rggen_bus_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rggen_bus_arbiter.sv
// Shares one rggen register-bus slave between HOSTS masters: arbitrates, forwards the
// winning command with zero added latency, and locks the grant until the slave is ready.
module rggen_bus_arbiter #(
    parameter int unsigned HOSTS          = 2,
    parameter int unsigned ADDRESS_WIDTH  = 8,
    parameter int unsigned BUS_WIDTH      = 32,
    parameter bit          FIXED_PRIORITY = 1'b0
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [HOSTS-1:0]                      i_host_valid,
    input  logic [HOSTS-1:0][1:0]                 i_host_access,
    input  logic [HOSTS-1:0][ADDRESS_WIDTH-1:0]   i_host_address,
    input  logic [HOSTS-1:0][BUS_WIDTH-1:0]       i_host_write_data,
    input  logic [HOSTS-1:0][BUS_WIDTH/8-1:0]     i_host_strobe,
    output logic [HOSTS-1:0]                      o_host_ready,
    output logic [HOSTS-1:0][1:0]                 o_host_status,
    output logic [HOSTS-1:0][BUS_WIDTH-1:0]       o_host_read_data,
    output logic                                  o_slave_valid,
    output logic [1:0]                            o_slave_access,
    output logic [ADDRESS_WIDTH-1:0]              o_slave_address,
    output logic [BUS_WIDTH-1:0]                  o_slave_write_data,
    output logic [BUS_WIDTH/8-1:0]                o_slave_strobe,
    input  logic                                  i_slave_ready,
    input  logic [1:0]                            i_slave_status,
    input  logic [BUS_WIDTH-1:0]                  i_slave_read_data
);

    localparam int unsigned IDX_W = (HOSTS > 1) ? $clog2(HOSTS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] rr_q;

    logic [IDX_W-1:0] winner;
    logic             found;
    int unsigned      cand;
    logic             any_valid;
    logic [IDX_W-1:0] sel;
    logic             slave_valid_c;
    logic             done_c;

    function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx);
        if (32'(idx) == HOSTS - 1) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

    // Winner search: upward from the rr pointer with wrap, or from index 0 in fixed mode.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        for (int unsigned i = 0; i < HOSTS; i++) begin
            cand = FIXED_PRIORITY ? i : 32'(rr_q) + i;
            if (cand >= HOSTS) begin
                cand = cand - HOSTS;
            end
            if (!found && i_host_valid[IDX_W'(cand)]) begin
                found  = 1'b1;
                winner = IDX_W'(cand);
            end
        end
    end

    assign any_valid = |i_host_valid;
    assign sel       = (state_q == BUSY) ? grant_q : winner;

    // A slave ready only completes something when a transfer is live (or the grant is locked).
    always_comb begin
        slave_valid_c = 1'b0;
        done_c        = 1'b0;
        if (!i_rst) begin
            slave_valid_c = (state_q == IDLE) ? any_valid : i_host_valid[sel];
            done_c        = i_slave_ready && ((state_q == BUSY) || any_valid);
        end
    end

    always_comb begin
        o_slave_valid      = slave_valid_c;
        o_slave_access     = '0;
        o_slave_address    = '0;
        o_slave_write_data = '0;
        o_slave_strobe     = '0;
        o_host_ready       = '0;
        o_host_status      = '0;
        o_host_read_data   = '0;
        if (slave_valid_c) begin
            o_slave_access     = i_host_access[sel];
            o_slave_address    = i_host_address[sel];
            o_slave_write_data = i_host_write_data[sel];
            o_slave_strobe     = i_host_strobe[sel];
        end
        if (done_c) begin
            o_host_ready[sel]     = 1'b1;
            o_host_status[sel]    = i_slave_status;
            o_host_read_data[sel] = i_slave_read_data;
        end
    end

    // Grant lock and round-robin pointer update on completion.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        if (i_slave_ready) begin
                            if (!FIXED_PRIORITY) begin
                                rr_q <= next_index(winner);
                            end
                        end else begin
                            grant_q <= winner;
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (i_slave_ready) begin
                        if (!FIXED_PRIORITY) begin
                            rr_q <= next_index(grant_q);
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Directed bench for rggen_bus_arbiter: a cycle-by-cycle vector table on a round-robin
// instance plus hand-written sequences on a fixed-priority instance.
module tb_rggen_bus_arbiter;

    logic                  clk;
    logic                  rst;
    logic [1:0]            host_valid;
    logic [1:0][1:0]       host_access;
    logic [1:0][7:0]       host_address;
    logic [1:0][31:0]      host_wdata;
    logic [1:0][3:0]       host_strobe;
    logic                  slave_ready;
    logic [1:0]            slave_status;
    logic [31:0]           slave_rdata;

    logic [1:0]            rr_hready;
    logic [1:0][1:0]       rr_hstatus;
    logic [1:0][31:0]      rr_hrdata;
    logic                  rr_svalid;
    logic [1:0]            rr_saccess;
    logic [7:0]            rr_saddr;
    logic [31:0]           rr_swdata;
    logic [3:0]            rr_sstrobe;

    logic [1:0]            fp_hready;
    logic [1:0][1:0]       fp_hstatus;
    logic [1:0][31:0]      fp_hrdata;
    logic                  fp_svalid;
    logic [1:0]            fp_saccess;
    logic [7:0]            fp_saddr;
    logic [31:0]           fp_swdata;
    logic [3:0]            fp_sstrobe;

    int checks = 0;
    int errors = 0;

    rggen_bus_arbiter #(.HOSTS(2), .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .FIXED_PRIORITY(1'b0)) dut_rr (
        .i_clk(clk), .i_rst(rst),
        .i_host_valid(host_valid), .i_host_access(host_access), .i_host_address(host_address),
        .i_host_write_data(host_wdata), .i_host_strobe(host_strobe),
        .o_host_ready(rr_hready), .o_host_status(rr_hstatus), .o_host_read_data(rr_hrdata),
        .o_slave_valid(rr_svalid), .o_slave_access(rr_saccess), .o_slave_address(rr_saddr),
        .o_slave_write_data(rr_swdata), .o_slave_strobe(rr_sstrobe),
        .i_slave_ready(slave_ready), .i_slave_status(slave_status), .i_slave_read_data(slave_rdata)
    );

    rggen_bus_arbiter #(.HOSTS(2), .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .FIXED_PRIORITY(1'b1)) dut_fp (
        .i_clk(clk), .i_rst(rst),
        .i_host_valid(host_valid), .i_host_access(host_access), .i_host_address(host_address),
        .i_host_write_data(host_wdata), .i_host_strobe(host_strobe),
        .o_host_ready(fp_hready), .o_host_status(fp_hstatus), .o_host_read_data(fp_hrdata),
        .o_slave_valid(fp_svalid), .o_slave_access(fp_saccess), .o_slave_address(fp_saddr),
        .o_slave_write_data(fp_swdata), .o_slave_strobe(fp_sstrobe),
        .i_slave_ready(slave_ready), .i_slave_status(slave_status), .i_slave_read_data(slave_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  v;
        logic        rdy;
        logic [1:0]  st;
        logic [31:0] rd;
        logic        e_sv;
        int          e_sel;
        logic [1:0]  e_hr;
        logic [3:0]  e_st;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic r, input logic [1:0] v, input logic rdy,
                                input logic [1:0] st, input logic [31:0] rd,
                                input logic e_sv, input int e_sel, input logic [1:0] e_hr,
                                input logic [3:0] e_st, input logic [31:0] e_rd0,
                                input logic [31:0] e_rd1);
        vec_t x;
        x.rst = r; x.v = v; x.rdy = rdy; x.st = st; x.rd = rd;
        x.e_sv = e_sv; x.e_sel = e_sel; x.e_hr = e_hr; x.e_st = e_st;
        x.e_rd0 = e_rd0; x.e_rd1 = e_rd1;
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] v, input logic rdy,
                         input logic [1:0] st, input logic [31:0] rd);
        @(negedge clk);
        rst = r; host_valid = v; slave_ready = rdy; slave_status = st; slave_rdata = rd;
        #2;
    endtask

    // Checks the fixed-priority instance's slave command and host-ready for one cycle.
    task automatic check_fp(input string name, input logic e_sv, input int e_sel,
                            input logic [1:0] e_hr);
        check({name, " sv"}, 64'(fp_svalid), 64'(e_sv));
        check({name, " hr"}, 64'(fp_hready), 64'(e_hr));
        if (e_sv) begin
            check({name, " addr"}, 64'(fp_saddr), 64'(host_address[e_sel]));
        end
    endtask

    initial begin
        rst          = 1'b1;
        host_valid   = 2'b00;
        host_access  = {2'b11, 2'b00};
        host_address = {8'h20, 8'h10};
        host_wdata   = {32'h2222_2222, 32'h1111_1111};
        host_strobe  = {4'h3, 4'hF};
        slave_ready  = 1'b0;
        slave_status = 2'b00;
        slave_rdata  = '0;

        //            rst v    rdy st  rd             sv sel hr    st       rd0            rd1
        vecs[0]  = mk(1, 2'b00, 0, 0, 32'h0,         0, 0, 2'b00, 4'h0, 32'h0,         32'h0);
        vecs[1]  = mk(1, 2'b11, 1, 2, 32'hDEAD_BEEF, 0, 0, 2'b00, 4'h0, 32'h0,         32'h0);
        vecs[2]  = mk(0, 2'b00, 0, 0, 32'h0,         0, 0, 2'b00, 4'h0, 32'h0,         32'h0);
        vecs[3]  = mk(0, 2'b00, 1, 2, 32'h1234_5678, 0, 0, 2'b00, 4'h0, 32'h0,         32'h0);
        vecs[4]  = mk(0, 2'b00, 0, 0, 32'h0,         0, 0, 2'b00, 4'h0, 32'h0,         32'h0);
        vecs[5]  = mk(0, 2'b11, 0, 0, 32'h0,         1, 0, 2'b00, 4'h0, 32'h0,         32'h0);
        vecs[6]  = mk(0, 2'b11, 1, 0, 32'hA5A5_A5A5, 1, 0, 2'b01, 4'h0, 32'hA5A5_A5A5, 32'h0);
        vecs[7]  = mk(0, 2'b10, 0, 0, 32'h0,         1, 1, 2'b00, 4'h0, 32'h0,         32'h0);
        vecs[8]  = mk(0, 2'b10, 1, 0, 32'h0BAD_F00D, 1, 1, 2'b10, 4'h0, 32'h0,         32'h0BAD_F00D);
        vecs[9]  = mk(0, 2'b00, 0, 0, 32'h0,         0, 0, 2'b00, 4'h0, 32'h0,         32'h0);
        vecs[10] = mk(0, 2'b11, 1, 0, 32'h1,         1, 0, 2'b01, 4'h0, 32'h1,         32'h0);
        vecs[11] = mk(0, 2'b11, 1, 0, 32'h2,         1, 1, 2'b10, 4'h0, 32'h0,         32'h2);
        vecs[12] = mk(0, 2'b11, 1, 0, 32'h3,         1, 0, 2'b01, 4'h0, 32'h3,         32'h0);
        vecs[13] = mk(0, 2'b11, 1, 0, 32'h4,         1, 1, 2'b10, 4'h0, 32'h0,         32'h4);
        vecs[14] = mk(0, 2'b10, 0, 0, 32'h0,         1, 1, 2'b00, 4'h0, 32'h0,         32'h0);
        vecs[15] = mk(0, 2'b11, 0, 0, 32'h0,         1, 1, 2'b00, 4'h0, 32'h0,         32'h0);
        vecs[16] = mk(0, 2'b11, 0, 0, 32'h0,         1, 1, 2'b00, 4'h0, 32'h0,         32'h0);
        vecs[17] = mk(0, 2'b11, 1, 2, 32'hCAFE_F00D, 1, 1, 2'b10, 4'h8, 32'h0,         32'hCAFE_F00D);
        vecs[18] = mk(0, 2'b01, 1, 0, 32'h55,        1, 0, 2'b01, 4'h0, 32'h55,        32'h0);
        vecs[19] = mk(0, 2'b01, 0, 0, 32'h0,         1, 0, 2'b00, 4'h0, 32'h0,         32'h0);
        vecs[20] = mk(0, 2'b00, 0, 0, 32'h0,         0, 0, 2'b00, 4'h0, 32'h0,         32'h0);
        vecs[21] = mk(0, 2'b10, 1, 1, 32'h77,        0, 0, 2'b01, 4'h1, 32'h77,        32'h0);
        vecs[22] = mk(0, 2'b00, 0, 0, 32'h0,         0, 0, 2'b00, 4'h0, 32'h0,         32'h0);
        vecs[23] = mk(0, 2'b10, 0, 0, 32'h0,         1, 1, 2'b00, 4'h0, 32'h0,         32'h0);
        vecs[24] = mk(1, 2'b10, 1, 0, 32'h99,        0, 0, 2'b00, 4'h0, 32'h0,         32'h0);
        vecs[25] = mk(0, 2'b11, 1, 0, 32'h66,        1, 0, 2'b01, 4'h0, 32'h66,        32'h0);
        vecs[26] = mk(0, 2'b00, 0, 0, 32'h0,         0, 0, 2'b00, 4'h0, 32'h0,         32'h0);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].rdy, vecs[i].st, vecs[i].rd);
            check($sformatf("v%0d slave_valid", i), 64'(rr_svalid), 64'(vecs[i].e_sv));
            check($sformatf("v%0d host_ready", i), 64'(rr_hready), 64'(vecs[i].e_hr));
            check($sformatf("v%0d host_status", i), 64'(rr_hstatus), 64'(vecs[i].e_st));
            check($sformatf("v%0d read_data0", i), 64'(rr_hrdata[0]), 64'(vecs[i].e_rd0));
            check($sformatf("v%0d read_data1", i), 64'(rr_hrdata[1]), 64'(vecs[i].e_rd1));
            if (vecs[i].e_sv) begin
                check($sformatf("v%0d slave_addr", i), 64'(rr_saddr),
                      64'(host_address[vecs[i].e_sel]));
                check($sformatf("v%0d slave_access", i), 64'(rr_saccess),
                      64'(host_access[vecs[i].e_sel]));
                check($sformatf("v%0d slave_wdata", i), 64'(rr_swdata),
                      64'(host_wdata[vecs[i].e_sel]));
                check($sformatf("v%0d slave_strobe", i), 64'(rr_sstrobe),
                      64'(host_strobe[vecs[i].e_sel]));
            end
        end

        // Fixed priority: host0 wins every zero-wait cycle while it stays valid.
        drive(1, 2'b00, 0, 0, 32'h0);
        check_fp("fp reset", 1'b0, 0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            drive(0, 2'b11, 1, 0, 32'(i + 16));
            check_fp($sformatf("fp both%0d", i), 1'b1, 0, 2'b01);
            check($sformatf("fp both%0d rd0", i), 64'(fp_hrdata[0]), 64'(i + 16));
        end
        drive(0, 2'b10, 1, 0, 32'h42);
        check_fp("fp host1 alone", 1'b1, 1, 2'b10);
        check("fp host1 rd1", 64'(fp_hrdata[1]), 64'h42);

        // Fixed priority with a stall: host0 locked, host1 only after host0 completes.
        drive(0, 2'b11, 0, 0, 32'h0);
        check_fp("fp stall0", 1'b1, 0, 2'b00);
        drive(0, 2'b11, 0, 0, 32'h0);
        check_fp("fp stall1", 1'b1, 0, 2'b00);
        drive(0, 2'b11, 1, 2, 32'h5A);
        check_fp("fp stall done", 1'b1, 0, 2'b01);
        check("fp stall status", 64'(fp_hstatus), 64'h2);
        drive(0, 2'b10, 1, 0, 32'h0);
        check_fp("fp host1 after", 1'b1, 1, 2'b10);
        drive(0, 2'b00, 0, 0, 32'h0);
        check_fp("fp idle", 1'b0, 0, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
